// File: rtl/cache_repl_policy.sv
// Per-set replacement state: tree-PLRU bits and round-robin pointers,
// plus a shared LFSR for random victim selection.
module cache_repl_policy #(
  parameter int NUMWAYS  = 4,
  parameter int SETLEN   = 9,
  parameter int NUMLINES = 128
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 Mode,
  input  logic [SETLEN-1:0]          CacheSet,
  input  logic [NUMWAYS-1:0]         HitWay,
  input  logic [NUMWAYS-1:0]         ValidWay,
  input  logic                       LRUWriteEn,
  input  logic                       SetValid,
  input  logic                       FlushStage,
  input  logic                       InvalidateCache,
  output logic [NUMWAYS-1:0]         VictimWay,
  output logic [$clog2(NUMWAYS)-1:0] VictimWayEnc
);

  localparam int LFSRLEN = 8;
  localparam int LOGW = $clog2(NUMWAYS);
  localparam int IDXW = (NUMLINES > 1) ? $clog2(NUMLINES) : 1;
  localparam logic [SETLEN:0] LINES = (SETLEN+1)'(NUMLINES);

  logic [NUMWAYS-2:0]   r_plru [NUMLINES];
  logic [LOGW-1:0]      r_rr   [NUMLINES];
  logic [LFSRLEN-1:0]   r_lfsr;

  logic                 w_ok;
  logic                 w_upd;
  logic [IDXW-1:0]      w_idx;
  logic [NUMWAYS-2:0]   w_plru;
  logic [NUMWAYS-2:0]   w_plru_nx;
  logic [LOGW-1:0]      w_rr;
  logic [LOGW-1:0]      w_tree;
  logic [LOGW-1:0]      w_inv;
  logic [LOGW-1:0]      w_hit;
  logic [LOGW-1:0]      w_u;
  logic [LFSRLEN-1:0]   w_lfsr_nx;

  assign w_ok   = {1'b0, CacheSet} < LINES;
  assign w_idx  = CacheSet[IDXW-1:0];
  assign w_plru = w_ok ? r_plru[w_idx] : '0;
  assign w_rr   = w_ok ? r_rr[w_idx] : '0;

  // Heap-ordered tree: node n has children 2n+1 (lower) and 2n+2 (upper).
  always_comb begin
    logic [LOGW:0]        n;
    logic [2*NUMWAYS-1:0] x;
    x = '0;
    x[NUMWAYS-2:0] = w_plru;
    n = '0;
    w_tree = '0;
    for (int l = 0; l < LOGW; l++) begin
      w_tree[LOGW-1-l] = x[n];
      n = (n << 1) + (LOGW+1)'(1) + (LOGW+1)'(x[n]);
    end
  end

  always_comb begin
    w_inv = '0;
    for (int i = NUMWAYS-1; i >= 0; i--)
      if (!ValidWay[i]) w_inv = LOGW'(i);
  end

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUMWAYS; i++)
      if (HitWay[i]) w_hit = w_hit | LOGW'(i);
  end

  always_comb begin
    VictimWayEnc = w_tree;
    if (!(&ValidWay)) begin
      VictimWayEnc = w_inv;
    end else begin
      unique case (Mode)
        2'd1:    VictimWayEnc = r_lfsr[LOGW-1:0];
        2'd2:    VictimWayEnc = w_rr;
        default: VictimWayEnc = w_tree;
      endcase
    end
  end

  assign VictimWay = NUMWAYS'(1) << VictimWayEnc;
  assign w_u = SetValid ? VictimWayEnc : w_hit;

  // Each node on the update path is pointed away from the touched way.
  always_comb begin
    logic [LOGW:0]        n;
    logic [2*NUMWAYS-1:0] x;
    x = '0;
    x[NUMWAYS-2:0] = w_plru;
    n = '0;
    for (int l = 0; l < LOGW; l++) begin
      x[n] = ~w_u[LOGW-1-l];
      n = (n << 1) + (LOGW+1)'(1) + (LOGW+1)'(w_u[LOGW-1-l]);
    end
    w_plru_nx = x[NUMWAYS-2:0];
  end

  assign w_lfsr_nx = {r_lfsr[6:0],
                      r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

  assign w_upd = LRUWriteEn & ~FlushStage & ~InvalidateCache & w_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUMLINES; i++) begin
        r_plru[i] <= '0;
        r_rr[i]   <= '0;
      end
      r_lfsr <= 8'h01;
    end else if (InvalidateCache) begin
      for (int i = 0; i < NUMLINES; i++) begin
        r_plru[i] <= '0;
        r_rr[i]   <= '0;
      end
    end else if (w_upd) begin
      r_plru[w_idx] <= w_plru_nx;
      if (SetValid) begin
        r_rr[w_idx] <= r_rr[w_idx] + LOGW'(1);
        r_lfsr      <= w_lfsr_nx;
      end
    end
  end

endmodule

// File: tb/tb_cache_repl_policy.sv
// Directed bench for cache_repl_policy (4 ways, default sets).
module tb_cache_repl_policy;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Mode;
  logic [8:0] CacheSet;
  logic [3:0] HitWay;
  logic [3:0] ValidWay;
  logic       LRUWriteEn;
  logic       SetValid;
  logic       FlushStage;
  logic       InvalidateCache;
  logic [3:0] VictimWay;
  logic [1:0] VictimWayEnc;

  int n_chk = 0;
  int n_pass = 0;
  int exp_l [3] = '{1, 2, 0};

  cache_repl_policy dut (
    .clk(clk),
    .reset(reset),
    .Mode(Mode),
    .CacheSet(CacheSet),
    .HitWay(HitWay),
    .ValidWay(ValidWay),
    .LRUWriteEn(LRUWriteEn),
    .SetValid(SetValid),
    .FlushStage(FlushStage),
    .InvalidateCache(InvalidateCache),
    .VictimWay(VictimWay),
    .VictimWayEnc(VictimWayEnc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vic(input logic [1:0] m, input int e, input string tag);
    Mode = m;
    #1;
    chk(tag, 32'(VictimWayEnc), 32'(e));
  endtask

  task automatic fill();
    SetValid = 1'b1;
    LRUWriteEn = 1'b1;
    tick();
    SetValid = 1'b0;
    LRUWriteEn = 1'b0;
  endtask

  task automatic hit(input logic [3:0] w);
    HitWay = w;
    LRUWriteEn = 1'b1;
    tick();
    LRUWriteEn = 1'b0;
    HitWay = '0;
  endtask

  initial begin
    reset = 1'b1; Mode = '0; CacheSet = 9'd5; HitWay = '0;
    ValidWay = 4'hf; LRUWriteEn = 1'b0; SetValid = 1'b0;
    FlushStage = 1'b0; InvalidateCache = 1'b0;
    tick(); tick();
    reset = 1'b0;

    vic(0, 0, "rst_m0");
    vic(2, 0, "rst_m2");
    vic(3, 0, "rst_m3");
    vic(1, 1, "rst_m1");
    chk("rst_oh", 32'(VictimWay), 32'h2);

    ValidWay = 4'b1011;
    for (int m = 0; m < 4; m++) begin
      Mode = 2'(m);
      #1 chk("inv_way2", 32'(VictimWay), 32'h4);
    end
    ValidWay = 4'b0000;
    #1 chk("inv_none", 32'(VictimWay), 32'h1);
    ValidWay = 4'b0111;
    #1 chk("inv_way3", 32'(VictimWay), 32'h8);
    ValidWay = 4'hf;
    vic(1, 1, "inv_nochg");

    Mode = 0; HitWay = 4'b0001; LRUWriteEn = 1'b1;
    #1 chk("same_cyc", 32'(VictimWayEnc), 0);
    tick();
    LRUWriteEn = 1'b0; HitWay = '0;
    vic(0, 2, "plru_h0");
    vic(2, 0, "rr_hit");
    vic(1, 1, "lfsr_hit");
    Mode = 0;
    hit(4'b0100);
    vic(0, 1, "plru_h2");
    FlushStage = 1'b1;
    hit(4'b0010);
    FlushStage = 1'b0;
    vic(0, 1, "flush_hit");

    for (int k = 0; k < 5; k++) begin
      vic(2, k % 4, "rr_seq");
      if (k == 1) begin
        hit(4'b1000);
        vic(2, 1, "rr_after_hit");
      end
      if (k < 4) fill();
    end

    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vic(1, exp_l[k], "lfsr_seq");
      fill();
    end
    vic(1, 0, "lfsr_08");
    FlushStage = 1'b1;
    fill();
    FlushStage = 1'b0;
    vic(1, 0, "lfsr_flush");
    fill();
    vic(1, 1, "lfsr_11");

    CacheSet = 9'd6;
    vic(0, 0, "s6_m0");
    vic(2, 0, "s6_m2");
    Mode = 0;
    hit(4'b0001);
    vic(0, 2, "s6_h0");
    CacheSet = 9'd5;
    vic(0, 3, "s5_plru");
    vic(2, 0, "s5_rr");
    fill();
    vic(2, 1, "rr_pre_inv");
    vic(1, 3, "lfsr_23");

    Mode = 2;
    InvalidateCache = 1'b1; SetValid = 1'b1; LRUWriteEn = 1'b1;
    tick();
    InvalidateCache = 1'b0; SetValid = 1'b0; LRUWriteEn = 1'b0;
    vic(2, 0, "inv_rr");
    vic(0, 0, "inv_plru");
    CacheSet = 9'd6;
    vic(0, 0, "inv_s6");
    CacheSet = 9'd5;
    vic(1, 3, "inv_lfsr");

    CacheSet = 9'd200;
    Mode = 1;
    fill();
    Mode = 0;
    hit(4'b0001);
    vic(0, 0, "oor_plru");
    CacheSet = 9'd5;
    vic(1, 3, "oor_lfsr");

    Mode = 0;
    hit(4'b0000);
    vic(0, 2, "miss_w0");

    Mode = 2;
    fill();
    vic(2, 1, "pre_rst");
    reset = 1'b1; SetValid = 1'b1; LRUWriteEn = 1'b1;
    tick();
    reset = 1'b0; SetValid = 1'b0; LRUWriteEn = 1'b0;
    vic(1, 1, "rst_lfsr");
    vic(2, 0, "rst_rr");
    vic(0, 0, "rst_plru");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
